// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Purpose:
//   Sequencing controller for the 16-bit instruction-fetch stage. Each cycle it
//   decides whether the PC advances, is redirected or holds, and whether the
//   IF/ID register captures, holds or is squashed. It arbitrates a taken branch,
//   a load-use stall, a halt and instruction-memory wait states.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   stall_req    in   load-use hazard from ID; hold PC and IF/ID
//   br_taken     in   branch/jump resolved taken this cycle
//   br_target    in   redirect address, valid with br_taken
//   halt_req     in   halt instruction decoded in ID
//   im_ready     in   instruction memory output valid for pc_cur
//   pc_cur       in   current PC register value
//   pc_next      out  value loaded into PC when pc_we=1
//   pc_we        out  PC write enable
//   ifid_we      out  IF/ID register write enable
//   ifid_flush   out  IF/ID clear to NOP
//   fetch_valid  out  IF/ID captures a good instruction this cycle
//   halted       out  fetch permanently stopped (until rst)
//   bubble_cnt   out  saturating count of non-fetching cycles
//
// Handshake: there is no valid/ready pairing on this block. im_ready is a
//   level qualifier for pc_cur; a PC write only happens in a cycle where the
//   fetched word is consumed (im_ready=1) or discarded by a redirect.
//
// Configuration:
//   IF_FETCH_PERF_EN  defined   -> bubble_cnt is a live saturating counter
//                     undefined -> bubble_cnt is tied to zero, no flops
//
// Debug: the FSM state is held in state_q (type state_t) for hierarchical
//   observation by checkers.
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt_req,
  input  logic              im_ready,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              fetch_valid,
  output logic              halted,
  output logic [7:0]        bubble_cnt
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [ADDR_W-1:0] pc_inc;
  assign pc_inc = pc_cur + ADDR_W'(INC);  // wraps modulo 2^ADDR_W

  // Next state when the inputs are judged the way RUN judges them.
  function automatic state_t run_next(input logic br, input logic stall,
                                      input logic halt, input logic ready);
    if (br)          return RUN;
    else if (stall)  return STALL;
    else if (halt)   return HALT;
    else if (!ready) return WAIT;
    else             return RUN;
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  state_d = run_next(br_taken, stall_req, halt_req, im_ready);
      STALL: begin
        // Releasing the stall re-evaluates as RUN in the same cycle.
        if (stall_req && !br_taken) state_d = STALL;
        else state_d = run_next(br_taken, stall_req, halt_req, im_ready);
      end
      WAIT: begin
        if (!im_ready) begin
          // Remember the latest redirect seen while memory is busy.
          if (br_taken) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = br_target;
          end
        end else begin
          pend_vld_d = 1'b0;
          if (br_taken || pend_vld_q) state_d = RUN;
          else state_d = run_next(1'b0, stall_req, halt_req, 1'b1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              run_eval;

  always_comb begin
    pc_next     = pc_inc;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    redir       = 1'b0;
    redir_tgt   = br_target;
    run_eval    = 1'b0;

    if (rst) begin
      pc_next    = RESET_PC;
      ifid_flush = 1'b1;
    end else begin
      case (state_q)
        BOOT: begin
          pc_next    = RESET_PC;
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
        end
        RUN: begin
          run_eval = 1'b1;
          redir    = br_taken;
        end
        STALL: begin
          if (!stall_req || br_taken) begin
            run_eval = 1'b1;
            redir    = br_taken;
          end
        end
        WAIT: begin
          if (im_ready) begin
            // A live branch is younger than the pending one and wins.
            run_eval = 1'b1;
            redir    = br_taken || pend_vld_q;
            if (!br_taken) redir_tgt = pend_tgt_q;
          end
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase

      // Redirect squashes the word in flight: flush wins over capture.
      if (redir) begin
        pc_next    = redir_tgt;
        pc_we      = 1'b1;
        ifid_flush = 1'b1;
      end else if (run_eval && !stall_req && !halt_req && im_ready) begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        fetch_valid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bubble counter
  // ---------------------------------------------------------------------------
`ifdef IF_FETCH_PERF_EN
  logic [7:0] bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= 8'h00;
    end else if (state_q != BOOT && state_q != HALT && !fetch_valid &&
                 bubble_q != 8'hFF) begin
      bubble_q <= bubble_q + 8'h01;
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = 8'h00;
`endif

endmodule
